// File: rtl/compass_sched_if.sv
// compass_sched_if: result channel of the compass scheduler.
//   res_valid_o   scheduler -> consumer : result valid
//   res_id_o      scheduler -> consumer : requester id owning the result
//   res_count_o   scheduler -> consumer : detections counted in the burst
//   res_timeout_o scheduler -> consumer : burst ended by the idle watchdog
//   res_ready_i   consumer -> scheduler : result accept
// Signal names keep the scheduler-side _o/_i suffixes for traceability.
interface compass_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COUNT_W = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic               res_valid_o;
  logic [ID_W-1:0]    res_id_o;
  logic [COUNT_W-1:0] res_count_o;
  logic               res_timeout_o;
  logic               res_ready_i;

  modport master (
    output res_valid_o, res_id_o, res_count_o, res_timeout_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_id_o, res_count_o, res_timeout_o,
    output res_ready_i
  );
endinterface

// File: rtl/compass_sched.sv
// compass_sched: round-robin scheduler sharing one compass sequence detector
// between NUM_REQ direction-stream requesters, one whole burst at a time.
// The detector is cleared before every burst; after each burst the detection
// count and requester id are returned on the result channel.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   req_valid_i/_last_i   per-requester beat valid / final beat of burst
//   req_direction_i       requester k direction at bits [2k+1:2k]
//   req_ready_o           per-requester beat accept
//   det_valid_o, det_direction_o, det_reset_o  detector drive
//   det_detected_i        detector hit, same cycle as the beat
//   res                   result channel (compass_sched_if.master)
// Optional feature: define COMPASS_SCHED_TIMEOUT_EN to enable the idle-beat
// watchdog (TIMEOUT_CYCLES); otherwise res_timeout_o is always 0.
module compass_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [2*NUM_REQ-1:0]   req_direction_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   det_valid_o,
  output logic [1:0]             det_direction_o,
  output logic                   det_reset_o,
  input  logic                   det_detected_i,
  compass_sched_if.master        res
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_REPORT} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]    cand;
  logic               found;
  logic               stream_open;

`ifdef COMPASS_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_flag_q, tmo_flag_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      count_q <= '0;
`ifdef COMPASS_SCHED_TIMEOUT_EN
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      count_q <= count_d;
`ifdef COMPASS_SCHED_TIMEOUT_EN
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    count_d         = count_q;
    cand            = '0;
    found           = 1'b0;
    stream_open     = 1'b0;
    req_ready_o     = '0;
    det_valid_o     = 1'b0;
    det_direction_o = '0;
    det_reset_o     = 1'b0;
    res.res_valid_o   = 1'b0;
    res.res_id_o      = '0;
    res.res_count_o   = '0;
    res.res_timeout_o = 1'b0;
`ifdef COMPASS_SCHED_TIMEOUT_EN
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Scan rr_q+1, rr_q+2, ... so the last-served requester ranks lowest.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
          cand = ID_W'((32'(rr_q) + i) % NUM_REQ);
          if (!found && req_valid_i[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        det_reset_o = 1'b1;
        count_d     = '0;
        state_d     = S_STREAM;
`ifdef COMPASS_SCHED_TIMEOUT_EN
        tmo_d      = '0;
        tmo_flag_d = 1'b0;
`endif
      end

      S_STREAM: begin
`ifdef COMPASS_SCHED_TIMEOUT_EN
        // Watchdog expiry wins over a beat arriving in the same cycle.
        if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
          state_d    = S_REPORT;
          tmo_flag_d = 1'b1;
        end else begin
          stream_open = 1'b1;
        end
`else
        stream_open = 1'b1;
`endif
        if (stream_open) begin
          req_ready_o[grant_q] = 1'b1;
          det_valid_o          = req_valid_i[grant_q];
          det_direction_o      = req_direction_i[{grant_q, 1'b0} +: 2];
          if (req_valid_i[grant_q]) begin
            if (det_detected_i && (count_q != '1)) count_d = count_q + 1'b1;
            if (req_last_i[grant_q]) state_d = S_REPORT;
`ifdef COMPASS_SCHED_TIMEOUT_EN
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
`endif
          end
        end
      end

      S_REPORT: begin
        res.res_valid_o = 1'b1;
        res.res_id_o    = grant_q;
        res.res_count_o = count_q;
`ifdef COMPASS_SCHED_TIMEOUT_EN
        res.res_timeout_o = tmo_flag_q;
`endif
        if (res.res_ready_i) begin
          rr_d    = grant_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet during reset, with the detector held in clear.
    if (reset_i) begin
      req_ready_o       = '0;
      det_valid_o       = 1'b0;
      det_direction_o   = '0;
      det_reset_o       = 1'b1;
      res.res_valid_o   = 1'b0;
      res.res_id_o      = '0;
      res.res_count_o   = '0;
      res.res_timeout_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_compass_sched.sv
module tb_compass_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid;
  logic [7:0] dir;
  logic [3:0] last;
  logic       det;
  logic       rready;

  logic [3:0] ready1, ready2;
  logic       dv1, dv2, drst1, drst2;
  logic [1:0] dd1, dd2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  compass_sched_if #(.NUM_REQ(4), .COUNT_W(8)) rif1 ();
  compass_sched_if #(.NUM_REQ(4), .COUNT_W(2)) rif2 ();
  assign rif1.res_ready_i = rready;
  assign rif2.res_ready_i = rready;

  compass_sched #(.NUM_REQ(4), .COUNT_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .reset_i(rst), .req_valid_i(valid), .req_direction_i(dir),
    .req_last_i(last), .req_ready_o(ready1), .det_valid_o(dv1),
    .det_direction_o(dd1), .det_reset_o(drst1), .det_detected_i(det),
    .res(rif1.master)
  );

  compass_sched #(.NUM_REQ(4), .COUNT_W(2), .TIMEOUT_CYCLES(16)) dut_sat (
    .clk_i(clk), .reset_i(rst), .req_valid_i(valid), .req_direction_i(dir),
    .req_last_i(last), .req_ready_o(ready2), .det_valid_o(dv2),
    .det_direction_o(dd2), .det_reset_o(drst2), .det_detected_i(det),
    .res(rif2.master)
  );

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [7:0] dir;
    logic [3:0] last;
    logic       det;
    logic       rready;
    logic [3:0] e_ready;
    logic       e_dv;
    logic [1:0] e_dd;
    logic       e_drst;
    logic       e_rv;
    logic [1:0] e_rid;
    logic [7:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  // {ready, det_valid, det_dir, det_reset, res_valid, res_id, res_count, res_timeout}
  function automatic logic [19:0] outs();
    return {ready1, dv1, dd1, drst1, rif1.res_valid_o, rif1.res_id_o,
            rif1.res_count_o, rif1.res_timeout_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [7:0] d,
                     input logic [3:0] l, input logic dt, input logic rr,
                     input logic [3:0] er, input logic edv, input logic [1:0] edd,
                     input logic edr, input logic erv, input logic [1:0] eid,
                     input logic [7:0] erc);
    vec_t t;
    t.rst = r; t.valid = v; t.dir = d; t.last = l; t.det = dt; t.rready = rr;
    t.e_ready = er; t.e_dv = edv; t.e_dd = edd; t.e_drst = edr;
    t.e_rv = erv; t.e_rid = eid; t.e_rc = erc;
    vecs.push_back(t);
  endtask

  initial begin
    //    rst valid    dir    last     det rrdy  ready   dv dd    drst rv id     count
    // single burst, requester 0
    add(1, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v0 reset
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v1 idle
    add(0, 4'b0001, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v2 request
    add(0, 4'b0001, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v3 clear
    add(0, 4'b0001, 8'h00, 4'b0000, 0, 0, 4'b0001, 1, 2'd0, 0, 0, 2'd0, 8'd0); // v4 beat 00
    add(0, 4'b0001, 8'h00, 4'b0001, 1, 0, 4'b0001, 1, 2'd0, 0, 0, 2'd0, 8'd0); // v5 last, hit
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 1, 2'd0, 8'd1); // v6 report
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 0, 1, 2'd0, 8'd1); // v7 handshake
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v8 idle
    // contention: requesters 1 and 3 (dir 1=01, 3=11)
    add(0, 4'b1010, 8'hC4, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v9
    add(0, 4'b1010, 8'hC4, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v10 clear
    add(0, 4'b1010, 8'hC4, 4'b0000, 0, 0, 4'b0010, 1, 2'd1, 0, 0, 2'd0, 8'd0); // v11
    add(0, 4'b1010, 8'hC4, 4'b0010, 0, 0, 4'b0010, 1, 2'd1, 0, 0, 2'd0, 8'd0); // v12 last
    add(0, 4'b1000, 8'hC4, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 0, 1, 2'd1, 8'd0); // v13 report 1
    add(0, 4'b1000, 8'hC4, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v14 grant 3
    add(0, 4'b1000, 8'hC4, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v15 clear
    add(0, 4'b1000, 8'hC4, 4'b1000, 1, 1, 4'b1000, 1, 2'd3, 0, 0, 2'd0, 8'd0); // v16 last
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 0, 1, 2'd3, 8'd1); // v17 report 3
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v18 idle
    // fairness: 0 and 1 continuous single-beat bursts, ready tied high
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v19 grant 0
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v20
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0001, 1, 2'd0, 0, 0, 2'd0, 8'd0); // v21
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 0, 1, 2'd0, 8'd0); // v22 res 0
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v23 grant 1
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v24
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0010, 1, 2'd0, 0, 0, 2'd0, 8'd0); // v25
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 0, 1, 2'd1, 8'd0); // v26 res 1
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v27 grant 0
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 8'd0); // v28
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0001, 1, 2'd0, 0, 0, 2'd0, 8'd0); // v29
    add(0, 4'b0011, 8'h00, 4'b0011, 0, 1, 4'b0000, 0, 2'd0, 0, 1, 2'd0, 8'd0); // v30 res 0
    add(0, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 8'd0); // v31 idle

    rst = 1'b1; valid = '0; dir = '0; last = '0; det = 1'b0; rready = 1'b0;
    tick();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; valid = vecs[i].valid; dir = vecs[i].dir;
      last = vecs[i].last; det = vecs[i].det; rready = vecs[i].rready;
      #1;
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].e_ready, vecs[i].e_dv, vecs[i].e_dd, vecs[i].e_drst,
                 vecs[i].e_rv, vecs[i].e_rid, vecs[i].e_rc, 1'b0}));
      tick();
    end

    // Backpressure and saturation: requester 2, eight 00 beats, hits on odd beats.
    valid = 4'b0100; dir = '0; last = '0; det = 1'b0; rready = 1'b0;
    tick();
    #1 check("sat_clear", 32'({drst1, drst2, ready1}), 32'({1'b1, 1'b1, 4'b0000}));
    tick();
    for (int k = 0; k < 8; k++) begin
      det  = (k % 2) == 1;
      last = (k == 7) ? 4'b0100 : 4'b0000;
      #1 check($sformatf("sat_ready%0d", k), 32'({ready1, ready2}), 32'({4'b0100, 4'b0100}));
      tick();
    end
    valid = '0; last = '0; det = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1 check($sformatf("sat_hold%0d", j),
               32'({rif1.res_valid_o, rif1.res_id_o, rif1.res_count_o,
                    rif2.res_valid_o, rif2.res_count_o}),
               32'({1'b1, 2'd2, 8'd4, 1'b1, 2'd3}));
      tick();
    end
    rready = 1'b1;
    #1 check("sat_hs", 32'({rif1.res_valid_o, rif1.res_count_o, rif2.res_count_o}),
             32'({1'b1, 8'd4, 2'd3}));
    tick();
    rready = 1'b0;
    #1 check("sat_idle", 32'(outs()), 32'd0);
    tick();

    // Mid-burst reset: requester 3 streaming, reset, then requester 0 wins.
    valid = 4'b1000;
    tick();
    tick();
    det = 1'b1;
    #1 check("rst_pre", 32'(ready1), 32'(4'b1000));
    tick();
    rst = 1'b1; valid = 4'b1001; det = 1'b0;
    #1 check("rst_hold", 32'(outs()), 32'({4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0}));
    tick();
    rst = 1'b0;
    #1 check("rst_idle", 32'(outs()), 32'd0);
    tick();
    #1 check("rst_clear", 32'(outs()), 32'({4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0}));
    tick();
    last = 4'b1001;
    #1 check("rst_grant0", 32'({ready1, dv1}), 32'({4'b0001, 1'b1}));
    tick();
    valid = '0; last = '0; rready = 1'b1;
    #1 check("rst_result", 32'({rif1.res_valid_o, rif1.res_id_o, rif1.res_count_o}),
             32'({1'b1, 2'd0, 8'd0}));
    tick();
    rready = 1'b0;

`ifdef COMPASS_SCHED_TIMEOUT_EN
    // Watchdog: requester 1 sends one beat then stalls.
    valid = 4'b0010;
    tick();
    tick();
    #1 check("tmo_beat", 32'(ready1), 32'(4'b0010));
    tick();
    valid = '0;
    for (int s = 0; s < 16; s++) begin
      #1 check($sformatf("tmo_wait%0d", s), 32'({rif1.res_valid_o, ready1}), 32'({1'b0, 4'b0010}));
      tick();
    end
    valid = 4'b0010; last = 4'b0010;
    #1 check("tmo_reject", 32'({ready1, dv1}), 32'({4'b0000, 1'b0}));
    tick();
    valid = '0; last = '0; rready = 1'b1;
    #1 check("tmo_result", 32'({rif1.res_valid_o, rif1.res_id_o, rif1.res_count_o, rif1.res_timeout_o}),
             32'({1'b1, 2'd1, 8'd0, 1'b1}));
    tick();
    rready = 1'b0;
    #1 check("tmo_idle", 32'(outs()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
